gb_regbank: RTL and testbench
=============================

Name: gb_regbank

Overview:
- Parametrised host-accessible register bank on the ghostbus host interface (clk, addr, wdata, rdata, wen, rstb).
- Generalises single hand-placed ghostbus registers into NREG decoded registers at a configurable base address.
- Each register has a per-register mode: read-write, read-only (fabric-driven) or write-1-to-clear sticky status.
- Read data returns through a configurable-latency pipeline with a valid strobe.
- Instantiated once per module that needs a register block; rdata is OR-combinable with other bus slaves.

Parameters:
AW, 24, host address width
DW, 32, host data width
NREG, 8, number of registers (1..256)
BASE, 0, word address of register 0; bank occupies BASE..BASE+NREG-1
RD, 2, read latency in clk cycles from gb_rstb to gb_rvalid (1..8)
RO_MASK, 0, NREG bits; bit i=1 makes register i read-only
W1C_MASK, 0, NREG bits; bit i=1 makes register i write-1-to-clear
INIT, 0, NREG*DW bits; reset value of register i is INIT[i*DW +: DW]

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
gb_addr  input  AW  host word address
gb_wdata  input  DW  host write data
gb_wen  input  1  write strobe, one cycle per write
gb_rstb  input  1  read strobe, one cycle per read
gb_rdata  output  DW  read data, valid only with gb_rvalid, else 0
gb_rvalid  output  1  one-cycle pulse marking read data
reg_out  output  NREG*DW  current stored value of every register
reg_in  input  NREG*DW  fabric values for RO registers
status_set  input  NREG*DW  per-bit set requests for W1C registers
wr_pulse  output  NREG  one-cycle pulse: register i was written by host

Behaviour:
- Reset (rst_n low, async): every stored register to INIT slice; gb_rdata=0, gb_rvalid=0, wr_pulse=0; read pipeline flushed. Release is synchronous to the next clk edge; no spurious rvalid after reset, even if reset interrupted an in-flight read.
- Decode: hit when BASE <= gb_addr < BASE+NREG; index = gb_addr-BASE, computed at AW bits with no wrap past 2^AW. Misses are ignored entirely.
- Mode priority: RO_MASK over W1C_MASK; remaining registers are RW.
- Write (gb_wen & hit, edge N):
  - RW: register <= gb_wdata at edge N.
  - RO: ignored; wr_pulse still asserted.
  - W1C: register <= (register & ~gb_wdata) | status_set[i].
  - wr_pulse[index]=1 for the cycle after edge N.
- W1C set path: every cycle, W1C register i ORs in status_set[i] without a host write. On the same bit in the same cycle, set wins over clear.
- RO registers: no storage; reg_out slice = reg_in slice combinationally.
- Read (gb_rstb & hit, edge N):
  - Value sampled at edge N: stored value for RW/W1C, reg_in for RO.
  - gb_rdata=value and gb_rvalid=1 during the cycle after edge N+RD-1, i.e. exactly RD cycles after the strobe cycle.
  - Read miss: gb_rvalid stays 0 and gb_rdata stays 0.
- Throughput: one read per cycle. Back-to-back strobes produce back-to-back rvalid pulses in order; the pipeline is RD stages of {valid, data}.
- Simultaneous gb_wen and gb_rstb to the same address: read returns the pre-write value.
- gb_wen and gb_rstb to different addresses in the same cycle: both complete independently.

Test Plan:
- Reset: INIT reg1=32'h0000_0042, BASE=16, RD=2 -> after rst_n release, rstb addr 17 -> gb_rvalid pulse 2 cycles later with rdata 32'h42; rdata=0 on all other cycles.
- RW write/read: wen addr 16 wdata 32'hDEADBEEF -> wr_pulse[0] next cycle, reg_out[31:0]=32'hDEADBEEF; rstb addr 16 -> rdata 32'hDEADBEEF after 2 cycles.
- W1C: reg2 W1C; status_set[2] bit0,bit4 one cycle -> reg=32'h11. Write 32'h01 -> reg=32'h10. Write 32'h10 with status_set bit4 in the same cycle -> reg stays 32'h10.
- RO and miss: reg3 RO, reg_in=32'hCAFE -> write 32'h0 leaves read value 32'hCAFE; rstb addr 24 (miss) -> no rvalid, rdata 0.
- Pipelining and same-address collision: rstb on 4 consecutive cycles addrs 16..19 -> 4 consecutive rvalid pulses in order. wen+rstb addr 16 same cycle -> old value returned, new value on next read.
- Reset mid-read: rstb at cycle N, rst_n low at N+1 -> no rvalid ever for that read; all outputs at reset values.

Source files
------------

// File: rtl/gb_regbank.sv
// Host-accessible register bank on the ghostbus interface: NREG decoded registers
// with per-register RW / RO / W1C modes and a fixed-latency read pipeline.
module gb_regbank #(
    parameter int                   AW       = 24,
    parameter int                   DW       = 32,
    parameter int                   NREG     = 8,
    parameter int                   BASE     = 0,
    parameter int                   RD       = 2,
    parameter logic [NREG-1:0]      RO_MASK  = '0,
    parameter logic [NREG-1:0]      W1C_MASK = '0,
    parameter logic [NREG*DW-1:0]   INIT     = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AW-1:0]           gb_addr,
    input  logic [DW-1:0]           gb_wdata,
    input  logic                    gb_wen,
    input  logic                    gb_rstb,
    output logic [DW-1:0]           gb_rdata,
    output logic                    gb_rvalid,
    output logic [NREG*DW-1:0]      reg_out,
    input  logic [NREG*DW-1:0]      reg_in,
    input  logic [NREG*DW-1:0]      status_set,
    output logic [NREG-1:0]         wr_pulse
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    // Offset is taken one bit wider than the address so BASE+NREG never wraps.
    logic [AW:0]    off;
    logic           hit;
    logic [IW-1:0]  idx;
    logic           wr_hit;
    logic           rd_hit;

    assign off    = {1'b0, gb_addr} - (AW+1)'(BASE);
    assign hit    = ({1'b0, gb_addr} >= (AW+1)'(BASE)) && (off < (AW+1)'(NREG));
    assign idx    = off[IW-1:0];
    assign wr_hit = gb_wen & hit;
    assign rd_hit = gb_rstb & hit;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign reg_out[i*DW +: DW] = reg_in[i*DW +: DW];
        end else begin : g_st
            logic          wr_i;
            logic [DW-1:0] val_q;
            logic [DW-1:0] val_d;

            assign wr_i = wr_hit && (idx == IW'(i));

            // For W1C the set request is applied after the clear, so set wins.
            always_comb begin
                val_d = val_q;
                if (W1C_MASK[i]) begin
                    if (wr_i) val_d = val_q & ~gb_wdata;
                    val_d = val_d | status_set[i*DW +: DW];
                end else if (wr_i) begin
                    val_d = gb_wdata;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) val_q <= INIT[i*DW +: DW];
                else        val_q <= val_d;
            end

            assign reg_out[i*DW +: DW] = val_q;
        end
    end

    logic [DW-1:0] rd_val;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IW'(i)) rd_val = reg_out[i*DW +: DW];
        end
    end

    logic [NREG-1:0] wr_pulse_q;
    logic [NREG-1:0] wr_pulse_d;

    assign wr_pulse_d = wr_hit ? (NREG'(1) << idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_pulse_q <= '0;
        else        wr_pulse_q <= wr_pulse_d;
    end

    assign wr_pulse = wr_pulse_q;

    // Read pipeline: RD stages of {valid, data}; data is zero whenever valid is low.
    logic [RD-1:0] vld_q;
    logic [DW-1:0] dat_q [RD];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < RD; s++) dat_q[s] <= '0;
        end else begin
            vld_q[0] <= rd_hit;
            dat_q[0] <= rd_hit ? rd_val : '0;
            for (int s = 1; s < RD; s++) begin
                vld_q[s] <= vld_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign gb_rvalid = vld_q[RD-1];
    assign gb_rdata  = vld_q[RD-1] ? dat_q[RD-1] : '0;

    logic unused_ok;
    assign unused_ok = ^{off[AW:IW], reg_in, status_set};

endmodule

// File: tb/tb_gb_regbank.sv
// Bench for gb_regbank: directed plan steps then random traffic, every edge compared
// against a register-level model of the bank and its read latency.
module tb_gb_regbank;

    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int NREG = 8;
    localparam int BASE = 16;
    localparam int RD   = 2;
    localparam logic [NREG-1:0]    RO_M   = 8'b0100_1000;
    localparam logic [NREG-1:0]    W1C_M  = 8'b0110_0100;
    localparam logic [NREG*DW-1:0] INIT_P = {32'h0, 32'h0, 32'h0, 32'hA5A5_0004,
                                             32'h0, 32'h0, 32'h0000_0042, 32'h0};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [AW-1:0]        gb_addr;
    logic [DW-1:0]        gb_wdata;
    logic                 gb_wen;
    logic                 gb_rstb;
    logic [DW-1:0]        gb_rdata;
    logic                 gb_rvalid;
    logic [NREG*DW-1:0]   reg_out;
    logic [NREG*DW-1:0]   reg_in;
    logic [NREG*DW-1:0]   status_set;
    logic [NREG-1:0]      wr_pulse;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gb_regbank #(
        .AW(AW), .DW(DW), .NREG(NREG), .BASE(BASE), .RD(RD),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .INIT(INIT_P)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
        .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata), .gb_rvalid(gb_rvalid),
        .reg_out(reg_out), .reg_in(reg_in), .status_set(status_set), .wr_pulse(wr_pulse)
    );

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } rd_t;

    logic [DW-1:0]      m_reg [NREG];
    rd_t                pipe [$];
    logic [NREG*DW-1:0] init_v;
    logic [NREG-1:0]    ro_v;
    logic [NREG-1:0]    w1c_v;

    task automatic chk(input string tag, input logic [NREG*DW-1:0] obs,
                       input logic [NREG*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = init_v[i*DW +: DW];
        pipe.delete();
        for (int s = 0; s < RD-1; s++) pipe.push_back('0);
    endtask

    function automatic logic [DW-1:0] m_view(input int i);
        return ro_v[i] ? reg_in[i*DW +: DW] : m_reg[i];
    endfunction

    function automatic logic [NREG*DW-1:0] exp_out();
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = m_view(i);
        return v;
    endfunction

    // One clock: drive at negedge, update model at the edge, compare 1 ns later.
    task automatic step(input logic wen, input logic rstb, input int addr,
                        input logic [DW-1:0] wdata, input logic [NREG*DW-1:0] set);
        bit            hit;
        int            ix;
        rd_t           e;
        logic [NREG-1:0] exp_p;
        @(negedge clk);
        gb_wen = wen; gb_rstb = rstb; gb_addr = addr[AW-1:0];
        gb_wdata = wdata; status_set = set;
        hit = (addr >= BASE) && (addr < BASE + NREG);
        ix  = addr - BASE;
        e.v = rstb && hit;
        e.d = e.v ? m_view(ix) : '0;
        pipe.push_back(e);
        @(posedge clk);
        #1;
        exp_p = '0;
        for (int i = 0; i < NREG; i++) begin
            bit wr_this = wen && hit && (ix == i);
            if (wr_this) exp_p[i] = 1'b1;
            if (ro_v[i]) continue;
            if (w1c_v[i]) m_reg[i] = (wr_this ? (m_reg[i] & ~wdata) : m_reg[i]) | set[i*DW +: DW];
            else if (wr_this) m_reg[i] = wdata;
        end
        e = pipe.pop_front();
        chk("rvalid",   gb_rvalid, e.v);
        chk("rdata",    gb_rdata,  e.d);
        chk("wr_pulse", wr_pulse,  exp_p);
        chk("reg_out",  reg_out,   exp_out());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, '0);
    endtask

    logic [NREG*DW-1:0] rset;
    int                 r;
    int                 a;

    initial begin
        init_v = INIT_P; ro_v = RO_M; w1c_v = W1C_M;
        rst_n = 1'b0; gb_wen = 0; gb_rstb = 0; gb_addr = '0; gb_wdata = '0;
        status_set = '0; reg_in = '0;
        reg_in[3*DW +: DW] = 32'h0000_CAFE;
        reg_in[6*DW +: DW] = 32'h1357_9BDF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid",  gb_rvalid, 1'b0);
        chk("rst_rdata",   gb_rdata,  '0);
        chk("rst_wpulse",  wr_pulse,  '0);
        chk("rst_reg_out", reg_out,   exp_out());
        chk("rst_reg1",    reg_out[1*DW +: DW], 32'h42);
        @(negedge clk);
        rst_n = 1'b1;

        idle(1);
        step(0, 1, 17, '0, '0);
        idle(2);

        step(1, 0, 16, 32'hDEADBEEF, '0);
        chk("rw_reg0", reg_out[31:0], 32'hDEADBEEF);
        step(0, 1, 16, '0, '0);
        idle(2);

        rset = '0; rset[2*DW +: DW] = 32'h11;
        step(0, 0, 0, '0, rset);
        chk("w1c_set", reg_out[2*DW +: DW], 32'h11);
        step(1, 0, 18, 32'h01, '0);
        chk("w1c_clr", reg_out[2*DW +: DW], 32'h10);
        rset = '0; rset[2*DW +: DW] = 32'h10;
        step(1, 0, 18, 32'h10, rset);
        chk("w1c_setwins", reg_out[2*DW +: DW], 32'h10);

        step(1, 0, 19, 32'h0, '0);
        step(0, 1, 19, '0, '0);
        idle(1);
        chk("ro_read", gb_rdata, 32'h0000_CAFE);
        step(0, 1, 24, '0, '0);
        idle(2);
        rset = '0; rset[6*DW +: DW] = 32'hFFFF_FFFF;
        step(1, 1, 22, 32'hFFFF_FFFF, rset);
        idle(2);

        for (int k = 0; k < 4; k++) step(0, 1, 16 + k, '0, '0);
        idle(2);
        step(1, 1, 16, 32'h1234_5678, '0);
        step(0, 1, 16, '0, '0);
        idle(1);
        chk("collide_new", gb_rdata, 32'h1234_5678);
        idle(1);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                reg_in[3*DW +: DW] = $urandom;
                reg_in[6*DW +: DW] = $urandom;
            end
            r = $urandom_range(0, 19);
            a = (r == 0) ? 0 : (r == 1) ? 24'hFF_FFFF : $urandom_range(BASE - 2, BASE + NREG + 1);
            for (int i = 0; i < NREG; i++) rset[i*DW +: DW] = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 1) == 0) rset = '0;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, $urandom, rset);
        end
        idle(RD);

        step(0, 1, 17, '0, '0);
        @(negedge clk);
        rst_n = 1'b0; gb_rstb = 0; gb_wen = 0; status_set = '0;
        #1;
        model_reset();
        chk("mid_rvalid",  gb_rvalid, 1'b0);
        chk("mid_rdata",   gb_rdata,  '0);
        chk("mid_wpulse",  wr_pulse,  '0);
        chk("mid_reg_out", reg_out,   exp_out());
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("mid_hold_rvalid", gb_rvalid, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        step(0, 1, 17, '0, '0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
